// File: rtl/pulse_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : pulse_cnt_bank
// Description : Multi-channel gated edge counter. Each asynchronous input is
//               synchronised, edge-detected according to a shared mode, and
//               counted over a fixed window of WINDOW clocks. At the end of
//               each window every channel's count is snapshotted to o_data
//               with a one-cycle o_valid strobe. The counters then restart
//               with no dead cycle between windows.
//
// Ports       : i_clk    - system clock
//               i_rst    - asynchronous active-high reset, clears all state
//               i_run    - level enable; windows run while high
//               i_mode   - edge select: 00 rising, 01 falling, 10 both, 11 none
//               i_cnt    - asynchronous inputs, bit n = channel n
//               o_data   - snapshot counts, channel n at [n*BITS +: BITS]
//               o_valid  - one-cycle strobe, o_data/o_ovf updated this cycle
//               o_ovf    - per channel: count passed all-ones in that window
//               o_busy   - high while a window is in progress
//
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module pulse_cnt_bank #(
    parameter int CHANNELS    = 4,
    parameter int BITS        = 16,
    parameter int WINDOW      = 1000,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_run,
    input  logic [1:0]               i_mode,
    input  logic [CHANNELS-1:0]      i_cnt,
    output logic [CHANNELS*BITS-1:0] o_data,
    output logic                     o_valid,
    output logic [CHANNELS-1:0]      o_ovf,
    output logic                     o_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_TW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [c_TW-1:0] c_TERM  = c_TW'(WINDOW - 1);
    localparam logic [BITS-1:0] c_ONES  = '1;

    localparam logic [1:0] c_MODE_RISE = 2'b00;
    localparam logic [1:0] c_MODE_FALL = 2'b01;
    localparam logic [1:0] c_MODE_BOTH = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Synchroniser chain and previous-value register.
    // These run in every state so that the edge detector already holds a
    // settled history when a window starts.
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] r_prev;
    logic [CHANNELS-1:0] w_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_cnt;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Edge detection. i_mode is applied combinationally so a mode change
    // affects the very cycle it is presented in.
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] w_edge;

    always_comb begin
        w_edge = '0;
        case (i_mode)
            c_MODE_RISE: w_edge = w_sync & ~r_prev;
            c_MODE_FALL: w_edge = ~w_sync & r_prev;
            c_MODE_BOTH: w_edge = w_sync ^ r_prev;
            default:     w_edge = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Window state machine
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [c_TW-1:0] r_timer;
    logic            w_term;    // last cycle of the current window
    logic            w_count;   // accumulate this cycle's edges and advance

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_term       = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // The terminal cycle always completes its snapshot, even if
                // i_run drops on that same cycle.
                w_term  = (r_timer == c_TERM);
                w_count = i_run && !w_term;
                if (!i_run) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-channel next count. An edge on an all-ones counter either holds or
    // wraps depending on SATURATE and in both cases marks overflow.
    // ------------------------------------------------------------------------
    logic [BITS-1:0]     r_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_ovf_flag;
    logic [BITS-1:0]     w_cnt_next [CHANNELS];
    logic [CHANNELS-1:0] w_ovf_next;

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            w_cnt_next[n] = r_cnt[n] + BITS'(w_edge[n]);
            w_ovf_next[n] = r_ovf_flag[n];
            if (w_edge[n] && (r_cnt[n] == c_ONES)) begin
                w_cnt_next[n] = (SATURATE != 0) ? c_ONES : '0;
                w_ovf_next[n] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Counters, timer and registered outputs.
    // Whenever a cycle is not an accumulating one (IDLE, abort or terminal)
    // the counters, flags and timer fall back to zero, which is exactly what
    // a fresh window needs.
    // ------------------------------------------------------------------------
    logic [CHANNELS*BITS-1:0] r_data;
    logic [CHANNELS-1:0]      r_ovf;
    logic                     r_valid;
    logic                     r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_cnt[n] <= '0;
            end
            r_ovf_flag <= '0;
            r_timer    <= '0;
            r_data     <= '0;
            r_ovf      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_count) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    r_cnt[n] <= w_cnt_next[n];
                end
                r_ovf_flag <= w_ovf_next;
                r_timer    <= r_timer + 1'b1;
            end else begin
                for (int n = 0; n < CHANNELS; n++) begin
                    r_cnt[n] <= '0;
                end
                r_ovf_flag <= '0;
                r_timer    <= '0;
            end

            // The terminal cycle's own edges belong to the ending window.
            if (w_term) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    r_data[n*BITS +: BITS] <= w_cnt_next[n];
                end
                r_ovf <= w_ovf_next;
            end

            r_valid <= w_term;
            r_busy  <= (w_state_next == S_RUN);
        end
    end

    assign o_data  = r_data;
    assign o_ovf   = r_ovf;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pulse_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_cnt_bank
// Description : Scoreboard bench for pulse_cnt_bank. Two instances share the
//               stimulus, one wrapping and one saturating. A reference model
//               counts qualifying edges per window as plain integers and
//               derives wrap/saturate results and overflow arithmetically.
//               A separate monitor pops expectations on o_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_cnt_bank;

    localparam int CH  = 4;
    localparam int B   = 4;
    localparam int WIN = 50;
    localparam int SS  = 2;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          run    = 1'b0;
    logic [1:0]    mode   = 2'b00;
    logic [CH-1:0] cnt_in = '0;

    logic [CH*B-1:0] data_w, data_s;
    logic [CH-1:0]   ovf_w, ovf_s;
    logic            valid_w, valid_s, busy_w, busy_s;

    always #5 clk = ~clk;

    pulse_cnt_bank #(
        .CHANNELS(CH), .BITS(B), .WINDOW(WIN), .SYNC_STAGES(SS), .SATURATE(0)
    ) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_mode(mode), .i_cnt(cnt_in),
        .o_data(data_w), .o_valid(valid_w), .o_ovf(ovf_w), .o_busy(busy_w)
    );

    pulse_cnt_bank #(
        .CHANNELS(CH), .BITS(B), .WINDOW(WIN), .SYNC_STAGES(SS), .SATURATE(1)
    ) u_sat (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_mode(mode), .i_cnt(cnt_in),
        .o_data(data_s), .o_valid(valid_s), .o_ovf(ovf_s), .o_busy(busy_s)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [CH*B-1:0] dw;
        logic [CH-1:0]   ow;
        logic [CH*B-1:0] ds;
        logic [CH-1:0]   os;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          m_last;
    logic          m_run;
    int            m_pos;
    int            m_edges[CH];
    logic [CH-1:0] m_hist[$];      // input samples, newest first
    logic [CH-1:0] m_s, m_p, m_e;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic exp_t make_exp();
        exp_t x;
        int   lim;
        lim = 1 << B;
        for (int n = 0; n < CH; n++) begin
            x.dw[n*B +: B] = B'(m_edges[n] % lim);
            x.ow[n]        = (m_edges[n] >= lim);
            x.ds[n*B +: B] = (m_edges[n] >= lim - 1) ? B'(lim - 1) : B'(m_edges[n]);
            x.os[n]        = (m_edges[n] >= lim);
        end
        return x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_last = '0;
            for (int n = 0; n < CH; n++) m_edges[n] = 0;
            sb_q.delete();
            m_hist.delete();
            for (int k = 0; k <= SS; k++) m_hist.push_back('0);
        end else begin
            // An input sampled at one edge reaches the edge detector SS edges later.
            m_s = m_hist[SS-1];
            m_p = m_hist[SS];
            case (mode)
                2'b00:   m_e = m_s & ~m_p;
                2'b01:   m_e = ~m_s & m_p;
                2'b10:   m_e = m_s ^ m_p;
                default: m_e = '0;
            endcase
            m_hist.push_front(cnt_in);
            void'(m_hist.pop_back());

            if (!m_run) begin
                if (run) begin
                    m_run = 1'b1;
                    m_pos = 0;
                    for (int n = 0; n < CH; n++) m_edges[n] = 0;
                end
            end else begin
                for (int n = 0; n < CH; n++) m_edges[n] += int'(m_e[n]);
                if (m_pos == WIN - 1) begin
                    m_last = make_exp();
                    sb_q.push_back(m_last);
                    for (int n = 0; n < CH; n++) m_edges[n] = 0;
                    m_pos = 0;
                    m_run = run;
                end else if (!run) begin
                    m_run = 1'b0;
                    for (int n = 0; n < CH; n++) m_edges[n] = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    exp_t mon_exp;

    always @(negedge clk) begin
        if (valid_w || valid_s) begin
            chk("valid_wrap", 64'(valid_w), 64'd1);
            chk("valid_sat", 64'(valid_s), 64'd1);
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: got o_valid=1 expected no snapshot at %0t", $time);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("snap_data_wrap", 64'(data_w), 64'(mon_exp.dw));
                chk("snap_ovf_wrap", 64'(ovf_w), 64'(mon_exp.ow));
                chk("snap_data_sat", 64'(data_s), 64'(mon_exp.ds));
                chk("snap_ovf_sat", 64'(ovf_s), 64'(mon_exp.os));
            end
        end else begin
            chk("missed_valid", 64'(sb_q.size()), 64'd0);
            chk("hold_wrap", 64'({data_w, ovf_w}), 64'({m_last.dw, m_last.ow}));
            chk("hold_sat", 64'({data_s, ovf_s}), 64'({m_last.ds, m_last.os}));
        end
        chk("busy_wrap", 64'(busy_w), 64'(m_run));
        chk("busy_sat", 64'(busy_s), 64'(m_run));
    end

    // ------------------------------------------------------------------------
    // Stimulus (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int hold_left;

    initial begin
        // Channel 2 held high through reset; run right at release.
        rst    = 1'b1;
        run    = 1'b0;
        mode   = 2'b00;
        cnt_in = 4'b0100;
        repeat (4) step();
        rst = 1'b0;
        run = 1'b1;
        repeat (3 * WIN + 5) step();

        // Square wave on ch0 (period 10) through every mode, two windows each.
        cnt_in = '0;
        for (int md = 0; md < 4; md++) begin
            mode = 2'(md);
            for (int c = 0; c < 2 * WIN; c++) begin
                cnt_in[0] = ((c % 10) < 5);
                step();
            end
        end

        // Abort partway through a window, then resume.
        mode = 2'b10;
        for (int c = 0; c < WIN + 30; c++) begin
            cnt_in[0] = ((c % 6) < 3);
            run = !(c >= WIN + 10 && c < WIN + 14);
            step();
        end

        // Reset in the middle of a window with edges flowing.
        for (int c = 0; c < 25; c++) begin
            cnt_in = cnt_in ^ 4'(c);
            step();
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (WIN + 5) step();

        // Randomised traffic: dense toggling, mode changes, aborts and resets.
        hold_left = 0;
        for (int c = 0; c < 2500; c++) begin
            cnt_in = cnt_in ^ 4'($urandom);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom);
            if (hold_left > 0) begin
                hold_left--;
                run = (hold_left == 0);
            end else if ($urandom_range(0, 199) == 0) begin
                hold_left = $urandom_range(1, 5);
                run = 1'b0;
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        run = 1'b1;
        repeat (2 * WIN) step();

        run = 1'b0;
        repeat (5) step();
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
